// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit driving a word-wide request/grant/rvalid memory port.
// Latency: immediate error 1 cycle, aligned store 2 cycles, aligned load 3 cycles (minimum, acceptance to lsu_valid_o).
// Backpressure: takes one request at a time (lsu_ready_o only in IDLE); holds the memory request until mem_gnt_i or timeout.
//
// Ports: clk_i/rst_ni (synchronous active-low reset); lsu_* is the core-side request and completion
// interface; mem_* is the memory port (word-aligned address, byte enables, lane-shifted write data).
// Build option: define LSU_MISALIGNED_SPLIT_EN to split misaligned half/word accesses into two beats.
// Without it, those accesses return an error and the second-beat logic is not built.
module lsu_mem_master #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            lsu_req_i,
    output logic            lsu_ready_o,
    input  logic            lsu_we_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_sign_ext_i,
    output logic            lsu_valid_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_err_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP
    } state_t;

    // The timeout fires on the cycle the counter holds MAX_WAIT-1, so exactly
    // MAX_WAIT cycles are spent in one REQx/WAITx state before giving up.
    localparam logic [7:0] LP_TO_LAST = 8'(MAX_WAIT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic            r_we;
    logic            r_sext;
    logic            r_err;
    logic [1:0]      r_size;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_lo;

    logic [1:0]      w_off;
    logic [4:0]      w_sh;
    logic [7:0]      w_mask;
    logic [3:0]      w_be1;
    logic [XLEN-1:0] w_wd1;
    logic [XLEN-1:0] w_ext_src;
    logic [XLEN-1:0] w_ext;
    logic [XLEN-1:0] w_base;
    logic            w_split;
    logic            w_req_bad;
    logic            w_busy;
    logic            w_to;
    logic            w_to_fire;

    assign w_off  = r_addr[1:0];
    assign w_sh   = {w_off, 3'b000};
    assign w_base = {r_addr[XLEN-1:2], 2'b00};
    // n-byte lane mask before shifting to the access offset
    assign w_mask = (r_size == 2'b00) ? 8'h01 :
                    (r_size == 2'b01) ? 8'h03 : 8'h0F;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [XLEN-1:0]   r_hi;
    logic [7:0]        w_be_full;
    logic [2*XLEN-1:0] w_wd_full;
    logic [3:0]        w_be2;
    logic [XLEN-1:0]   w_wd2;

    // Lanes and data are computed over a two-word window; the upper half is beat 2.
    assign w_be_full = w_mask << w_off;
    assign w_wd_full = {{XLEN{1'b0}}, r_wdata} << w_sh;
    assign w_be1     = w_be_full[3:0];
    assign w_be2     = w_be_full[7:4];
    assign w_wd1     = w_wd_full[XLEN-1:0];
    assign w_wd2     = w_wd_full[2*XLEN-1:XLEN];
    assign w_ext_src = XLEN'({r_hi, r_lo} >> w_sh);
    assign w_split   = |w_be2;
    assign w_req_bad = (lsu_size_i == 2'b11);
`else
    assign w_be1     = 4'(w_mask << w_off);
    assign w_wd1     = r_wdata << w_sh;
    assign w_ext_src = r_lo >> w_sh;
    assign w_split   = 1'b0;
    assign w_req_bad = (lsu_size_i == 2'b11) ||
                       ((lsu_size_i == 2'b01) && (lsu_addr_i[1:0] == 2'b11)) ||
                       ((lsu_size_i == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`endif

    always_comb begin
        w_ext = w_ext_src;
        case (r_size)
            2'b00:   w_ext = {{(XLEN-8){r_sext & w_ext_src[7]}}, w_ext_src[7:0]};
            2'b01:   w_ext = {{(XLEN-16){r_sext & w_ext_src[15]}}, w_ext_src[15:0]};
            default: w_ext = w_ext_src;
        endcase
    end

    assign w_busy = (r_state == S_REQ1) || (r_state == S_WAIT1) ||
                    (r_state == S_REQ2) || (r_state == S_WAIT2);
    assign w_to   = (r_cnt == LP_TO_LAST);

    // A grant or rvalid arriving on the final wait cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_to_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_i) w_state_nxt = w_req_bad ? S_RESP : S_REQ1;
            end
            S_REQ1: begin
                if (mem_gnt_i)  w_state_nxt = r_we ? (w_split ? S_REQ2 : S_RESP) : S_WAIT1;
                else if (w_to) begin w_state_nxt = S_RESP; w_to_fire = 1'b1; end
            end
            S_WAIT1: begin
                if (mem_rvalid_i) w_state_nxt = w_split ? S_REQ2 : S_RESP;
                else if (w_to) begin w_state_nxt = S_RESP; w_to_fire = 1'b1; end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_REQ2: begin
                if (mem_gnt_i)  w_state_nxt = r_we ? S_RESP : S_WAIT2;
                else if (w_to) begin w_state_nxt = S_RESP; w_to_fire = 1'b1; end
            end
            S_WAIT2: begin
                if (mem_rvalid_i) w_state_nxt = S_RESP;
                else if (w_to) begin w_state_nxt = S_RESP; w_to_fire = 1'b1; end
            end
`endif
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_hi    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_busy && (w_state_nxt == r_state)) ? r_cnt + 8'd1 : 8'd0;
            if ((r_state == S_IDLE) && lsu_req_i) begin
                r_we    <= lsu_we_i;
                r_sext  <= lsu_sign_ext_i;
                r_size  <= lsu_size_i;
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_wdata_i;
                r_err   <= w_req_bad;
            end
            if (w_to_fire) r_err <= 1'b1;
            if ((r_state == S_WAIT1) && mem_rvalid_i) r_lo <= mem_rdata_i;
`ifdef LSU_MISALIGNED_SPLIT_EN
            if ((r_state == S_WAIT2) && mem_rvalid_i) r_hi <= mem_rdata_i;
`endif
        end
    end

    assign lsu_ready_o = (r_state == S_IDLE);
    assign lsu_valid_o = (r_state == S_RESP);
    assign lsu_err_o   = (r_state == S_RESP) && r_err;
    assign lsu_rdata_o = ((r_state == S_RESP) && !r_err && !r_we) ? w_ext : '0;

    assign mem_req_o = (r_state == S_REQ1) || (r_state == S_REQ2);
    assign mem_we_o  = mem_req_o && r_we;

    always_comb begin
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        if (r_state == S_REQ1) begin
            mem_addr_o  = w_base;
            mem_be_o    = w_be1;
            mem_wdata_o = w_wd1;
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        else if (r_state == S_REQ2) begin
            mem_addr_o  = w_base + XLEN'(4);
            mem_be_o    = w_be2;
            mem_wdata_o = w_wd2;
        end
`endif
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed table of transactions against a scripted memory responder.
// Latency: n/a (bench).
// Backpressure: grant and rvalid delays come from each table row.
module tb_lsu_mem_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i, lsu_ready_o, lsu_we_i, lsu_sign_ext_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic [1:0]  lsu_size_i;
    logic        lsu_valid_o, lsu_err_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    lsu_mem_master #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lsu_req_i(lsu_req_i), .lsu_ready_o(lsu_ready_o), .lsu_we_i(lsu_we_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_size_i(lsu_size_i),
        .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_valid_o(lsu_valid_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        int          gd;     // cycles of mem_req_o before grant (99 = never)
        int          rd;     // cycles after grant before rvalid (99 = never)
        logic [31:0] rd1;
        logic [31:0] rd2;
        int          nreq;   // expected number of granted beats
        logic [31:0] a1;
        logic [3:0]  b1;
        logic [31:0] w1;
        logic [31:0] a2;
        logic [3:0]  b2;
        logic [31:0] w2;
        int          lat;    // cycles from acceptance to lsu_valid_o
        logic        err;
        logic [31:0] res;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic sext, input int gd, input int rd,
                                input logic [31:0] rd1, input logic [31:0] rd2, input int nreq,
                                input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
                                input logic [31:0] a2, input logic [3:0] b2, input logic [31:0] w2,
                                input int lat, input logic err, input logic [31:0] res);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.sext = sext;
        v.gd = gd; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2; v.nreq = nreq;
        v.a1 = a1; v.b1 = b1; v.w1 = w1; v.a2 = a2; v.b2 = b2; v.w2 = w2;
        v.lat = lat; v.err = err; v.res = res;
        return v;
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v, input int idx);
        int  beat = 0;
        int  gcnt = 0;
        int  rcnt = 0;
        bit  rvp  = 0;
        bit  seen = 0;
        bit  done = 0;
        lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_addr_i = v.addr;
        lsu_wdata_i = v.wdata; lsu_size_i = v.size; lsu_sign_ext_i = v.sext;
        @(negedge clk_i);
        // captured inputs must not matter after acceptance
        lsu_req_i = 1'b0; lsu_we_i = ~v.we; lsu_addr_i = 32'hFFFF_FFFF;
        lsu_wdata_i = 32'h5555_5555; lsu_size_i = 2'b11; lsu_sign_ext_i = ~v.sext;
        for (int k = 1; k <= 40; k++) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0BAD_0BAD;
            if (lsu_valid_o) begin
                chk($sformatf("v%0d latency", idx), 96'(k), 96'(v.lat));
                chk($sformatf("v%0d err", idx), 96'(lsu_err_o), 96'(v.err));
                chk($sformatf("v%0d rdata", idx), 96'(lsu_rdata_o), 96'(v.res));
                chk($sformatf("v%0d beats", idx), 96'(beat), 96'(v.nreq));
                chk($sformatf("v%0d req_in_resp", idx), 96'(mem_req_o), 96'(0));
                done = 1;
                break;
            end
            if (mem_req_o) begin
                if (!seen) begin
                    seen = 1;
                    if (beat == 0)
                        chk($sformatf("v%0d beat1 we/addr/be/wdata", idx),
                            96'({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}),
                            96'({v.we, v.a1, v.b1, v.w1}));
                    else
                        chk($sformatf("v%0d beat2 we/addr/be/wdata", idx),
                            96'({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}),
                            96'({v.we, v.a2, v.b2, v.w2}));
                end
                if (gcnt == v.gd) begin
                    mem_gnt_i = 1'b1; rvp = !v.we; rcnt = 0; gcnt = 0; seen = 0; beat++;
                end else gcnt++;
            end else if (rvp) begin
                if (rcnt == v.rd) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = (beat == 1) ? v.rd1 : v.rd2;
                    rvp = 0;
                end else rcnt++;
            end
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL v%0d completion: got no lsu_valid_o within 40 cycles, required %0d", idx, v.lat);
        end else @(negedge clk_i);
        chk($sformatf("v%0d valid_one_cycle", idx), 96'(lsu_valid_o), 96'(0));
        chk($sformatf("v%0d ready_after", idx), 96'(lsu_ready_o), 96'(1));
    endtask

    initial begin
        // we, addr, wdata, size, sext, gd, rd, rd1, rd2, nreq, a1, b1, w1, a2, b2, w2, lat, err, res
        vq.push_back(mk(1, 'h10, 'hDEADBEEF, 2, 0, 0, 0, 0, 0, 1, 'h10, 'hF, 'hDEADBEEF, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(1, 'h23, 'h000000A5, 0, 0, 0, 0, 0, 0, 1, 'h20, 'h8, 'hA5000000, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(0, 'h23, 0, 0, 1, 0, 1, 'hA5123456, 0, 1, 'h20, 'h8, 0, 0, 0, 0, 4, 0, 'hFFFFFFA5));
        vq.push_back(mk(0, 'h23, 0, 0, 0, 0, 1, 'hA5123456, 0, 1, 'h20, 'h8, 0, 0, 0, 0, 4, 0, 'h000000A5));
        vq.push_back(mk(0, 'h06, 0, 1, 1, 0, 0, 'h80011234, 0, 1, 'h04, 'hC, 0, 0, 0, 0, 3, 0, 'hFFFF8001));
        vq.push_back(mk(0, 'h08, 0, 2, 0, 2, 0, 'h12345678, 0, 1, 'h08, 'hF, 0, 0, 0, 0, 5, 0, 'h12345678));
        vq.push_back(mk(1, 'h02, 'hCAFEBEEF, 1, 0, 0, 0, 0, 0, 1, 'h00, 'hC, 'hBEEF0000, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(0, 'h02, 0, 1, 0, 0, 0, 'hF00D1234, 0, 1, 'h00, 'hC, 0, 0, 0, 0, 3, 0, 'h0000F00D));
        vq.push_back(mk(0, 'h01, 0, 0, 1, 0, 0, 'h00007F00, 0, 1, 'h00, 'h2, 0, 0, 0, 0, 3, 0, 'h0000007F));
        vq.push_back(mk(1, 'h7D, 'hFFFFFF5A, 0, 0, 2, 0, 0, 0, 1, 'h7C, 'h2, 'hFFFF5A00, 0, 0, 0, 4, 0, 0));
        vq.push_back(mk(0, 'h40, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 'h30, 'h12345678, 2, 0, 99, 0, 0, 0, 0, 'h30, 'hF, 'h12345678, 0, 0, 0, 5, 1, 0));
        vq.push_back(mk(0, 'h34, 0, 2, 1, 0, 99, 'hFFFFFFFF, 0, 1, 'h34, 'hF, 0, 0, 0, 0, 6, 1, 0));
`ifdef LSU_MISALIGNED_SPLIT_EN
        vq.push_back(mk(0, 'h0D, 0, 2, 0, 0, 0, 'h44332211, 'h88776655, 2, 'h0C, 'hE, 0, 'h10, 'h1, 0, 5, 0, 'h55443322));
        vq.push_back(mk(1, 'h0E, 'h11223344, 2, 0, 0, 0, 0, 0, 2, 'h0C, 'hC, 'h33440000, 'h10, 'h3, 'h00001122, 3, 0, 0));
        vq.push_back(mk(0, 'h07, 0, 1, 1, 0, 0, 'h9A000000, 'h000000C3, 2, 'h04, 'h8, 0, 'h08, 'h1, 0, 5, 0, 'hFFFFC39A));
`else
        vq.push_back(mk(0, 'h0D, 0, 2, 0, 0, 0, 'h44332211, 'h88776655, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 'h0E, 'h11223344, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(0, 'h07, 0, 1, 1, 0, 0, 'h9A000000, 'h000000C3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`endif

        // Reset held two cycles with a request pending
        rst_ni = 1'b0; lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h10;
        lsu_wdata_i = 32'hDEADBEEF; lsu_size_i = 2'b10; lsu_sign_ext_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("reset ready/req/valid/err", 96'({lsu_ready_o, mem_req_o, lsu_valid_o, lsu_err_o}), 96'(4'b1000));
            chk("reset rdata/addr/wdata", 96'({lsu_rdata_o, mem_addr_o, mem_wdata_o}), 96'(0));
            chk("reset be/we", 96'({mem_be_o, mem_we_o}), 96'(0));
        end
        lsu_req_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (vq[i]) run_vec(vq[i], i);

        // Reset while REQ1 is waiting for a grant, then a stray grant/rvalid
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h40; lsu_size_i = 2'b10; lsu_sign_ext_i = 1'b0;
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        chk("midreset req_before", 96'(mem_req_o), 96'(1));
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midreset req/ready", 96'({mem_req_o, lsu_ready_o}), 96'(2'b01));
        rst_ni = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("stray valid/req/ready", 96'({lsu_valid_o, mem_req_o, lsu_ready_o}), 96'(3'b001));
        @(negedge clk_i);
        chk("stray valid_later", 96'(lsu_valid_o), 96'(0));
        run_vec(vq[4], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
